// File: rtl/upcnt_seq_arbiter_pkg.sv
// Shared types and helpers for the up-counter sequencer/arbiter.
//   state_t        : sequencer FSM states
//   WIDTH_DEF      : default counter data width
//   MAX_REQ        : largest supported requester count
//   idx_to_onehot  : binary requester index -> one-hot vector (MAX_REQ bits)
package upcnt_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } state_t;

    localparam int WIDTH_DEF = 4;
    localparam int MAX_REQ   = 8;
    localparam int MAX_IDX_W = 3;

    function automatic logic [MAX_REQ-1:0] idx_to_onehot(input logic [MAX_IDX_W-1:0] idx);
        logic [MAX_REQ-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/upcnt_seq_arbiter_if.sv
// Requester-side bus of the up-counter sequencer/arbiter.
//   req       : per-requester level request
//   start_val : packed per-requester load values
//   end_val   : packed per-requester terminal values
//   gnt       : one-hot ownership
//   done      : one-cycle completion pulse to the owner
//   busy      : sequencer is not idle
// master = requester side, slave = arbiter side.
interface upcnt_seq_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 4
);
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] start_val;
    logic [NUM_REQ*WIDTH-1:0] end_val;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    modport master (
        output req, start_val, end_val,
        input  gnt, done, busy
    );

    modport slave (
        input  req, start_val, end_val,
        output gnt, done, busy
    );
endinterface

// File: rtl/upcnt_seq_arbiter_rr_arbiter.sv
// Combinational round-robin picker.
//   req     : request vector
//   pointer : highest-priority index for this pick
//   enable  : qualifies the pick (only meaningful while idle)
//   grant   : one-hot winner, zero when not valid
//   index   : binary winner
//   valid   : a winner exists and enable is high
module rr_arbiter
    import upcnt_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   pointer,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    int   best_dist;
    logic found;

    // Winner is the set request with the smallest circular distance from pointer.
    always_comb begin
        index     = '0;
        found     = 1'b0;
        best_dist = NUM_REQ;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (req[j] && (((j - int'(pointer) + NUM_REQ) % NUM_REQ) < best_dist)) begin
                best_dist = (j - int'(pointer) + NUM_REQ) % NUM_REQ;
                index     = IDX_W'(j);
                found     = 1'b1;
            end
        end
        valid = found & enable;
        grant = valid ? NUM_REQ'(idx_to_onehot(MAX_IDX_W'(index))) : '0;
    end

endmodule

// File: rtl/upcnt_seq_arbiter.sv
// Sequencer/arbiter for a shared up-counter. Grants the counter to one
// requester at a time, loads its start value, lets it run to its end value,
// then pulses done.
//   clk, rst     : clock, asynchronous active-high reset
//   bus (slave)  : req/start_val/end_val in, gnt/done/busy out
//   cnt_rst      : counter reset
//   cnt_load     : counter load strobe
//   cnt_data_in  : counter load value
//   cnt_data_out : counter current value
module upcnt_seq_arbiter
    import upcnt_seq_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    upcnt_seq_arbiter_if.slave  bus,
    output logic                cnt_rst,
    output logic                cnt_load,
    output logic [WIDTH-1:0]    cnt_data_in,
    input  logic [WIDTH-1:0]    cnt_data_out
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_t             state;
    logic [IDX_W-1:0]   ptr;
    logic [IDX_W-1:0]   owner;
    logic [WIDTH-1:0]   end_lat;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IDX_W-1:0]   arb_idx;
    logic               arb_valid;
    logic               owner_req;
    logic [IDX_W-1:0]   ptr_next;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req     (bus.req),
        .pointer (ptr),
        .enable  (state == IDLE),
        .grant   (arb_oh),
        .index   (arb_idx),
        .valid   (arb_valid)
    );

    assign owner_req = bus.req[owner];
    assign ptr_next  = (owner == IDX_W'(NUM_REQ - 1)) ? '0 : owner + IDX_W'(1);

    // Outputs are assigned alongside the next state so every output is a
    // flop and nothing combinational leaks from req to gnt.
    // cnt_data_in doubles as the latched start value during LOAD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ptr         <= '0;
            owner       <= '0;
            end_lat     <= '0;
            bus.gnt     <= '0;
            bus.done    <= '0;
            bus.busy    <= 1'b0;
            cnt_rst     <= 1'b1;
            cnt_load    <= 1'b0;
            cnt_data_in <= '0;
        end else begin
            bus.done <= '0;
            case (state)
                IDLE: begin
                    if (arb_valid) begin
                        state       <= LOAD;
                        owner       <= arb_idx;
                        end_lat     <= bus.end_val[int'(arb_idx)*WIDTH +: WIDTH];
                        cnt_data_in <= bus.start_val[int'(arb_idx)*WIDTH +: WIDTH];
                        bus.gnt     <= arb_oh;
                        bus.busy    <= 1'b1;
                        cnt_rst     <= 1'b0;
                        cnt_load    <= 1'b1;
                    end
                end
                LOAD, RUN: begin
                    if (!owner_req) begin
                        // Abort: release without done, still rotate past owner.
                        state       <= IDLE;
                        ptr         <= ptr_next;
                        bus.gnt     <= '0;
                        bus.busy    <= 1'b0;
                        cnt_rst     <= 1'b1;
                        cnt_load    <= 1'b0;
                        cnt_data_in <= '0;
                    end else if (state == LOAD) begin
                        state       <= RUN;
                        cnt_load    <= 1'b0;
                        cnt_data_in <= '0;
                    end else if (cnt_data_out == end_lat) begin
                        state    <= DONE;
                        bus.done <= bus.gnt;
                        cnt_rst  <= 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    ptr      <= ptr_next;
                    bus.gnt  <= '0;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_upcnt_seq_arbiter.sv
module tb_upcnt_seq_arbiter;

    logic       clk;
    logic       rst;
    logic       cnt_rst;
    logic       cnt_load;
    logic [3:0] cnt_data_in;
    logic [3:0] cnt_data_out;

    int n_checks;
    int n_fail;
    int m_ptr;

    logic [3:0] drv_s [4];
    logic [3:0] drv_e [4];

    upcnt_seq_arbiter_if #(.NUM_REQ(4), .WIDTH(4)) bus ();

    upcnt_seq_arbiter #(.NUM_REQ(4), .WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .cnt_rst      (cnt_rst),
        .cnt_load     (cnt_load),
        .cnt_data_in  (cnt_data_in),
        .cnt_data_out (cnt_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The shared counter, per its contract.
    always @(posedge clk) begin
        if (cnt_rst)       cnt_data_out <= 4'd0;
        else if (cnt_load) cnt_data_out <= cnt_data_in;
        else               cnt_data_out <= cnt_data_out + 4'd1;
    end

    typedef struct {
        int         idx;
        logic [3:0] s;
        logic [3:0] e;
        int         run_len;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_vals();
        bus.start_val = {drv_s[3], drv_s[2], drv_s[1], drv_s[0]};
        bus.end_val   = {drv_e[3], drv_e[2], drv_e[1], drv_e[0]};
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_ptr = 0;
    endtask

    // One isolated transaction; starts and ends with the sequencer idle.
    task automatic run_single(input int idx, input logic [3:0] s, input logic [3:0] e,
                              input int run_len, input string tag);
        logic [3:0] oh;
        oh = 4'(1 << idx);
        drv_s[idx] = s;
        drv_e[idx] = e;
        drive_vals();
        bus.req = oh;
        @(negedge clk);
        chk({tag, " gnt_load"}, 32'(bus.gnt), 32'(oh));
        chk({tag, " cnt_load"}, 32'(cnt_load), 32'd1);
        chk({tag, " data_in"},  32'(cnt_data_in), 32'(s));
        chk({tag, " busy"},     32'(bus.busy), 32'd1);
        bus.start_val = 16'($urandom);
        bus.end_val   = 16'($urandom);
        for (int j = 0; j < run_len; j++) begin
            @(negedge clk);
            chk({tag, " data_out"}, 32'(cnt_data_out), 32'(4'(s + 4'(j))));
            chk({tag, " gnt_run"},  32'(bus.gnt), 32'(oh));
            chk({tag, " done_run"}, 32'(bus.done), 32'd0);
            chk({tag, " load_run"}, 32'(cnt_load), 32'd0);
        end
        @(negedge clk);
        chk({tag, " done"},     32'(bus.done), 32'(oh));
        chk({tag, " gnt_done"}, 32'(bus.gnt), 32'(oh));
        chk({tag, " rst_done"}, 32'(cnt_rst), 32'd1);
        bus.req = '0;
        @(negedge clk);
        chk({tag, " gnt_idle"},  32'(bus.gnt), 32'd0);
        chk({tag, " done_idle"}, 32'(bus.done), 32'd0);
        chk({tag, " busy_idle"}, 32'(bus.busy), 32'd0);
        @(negedge clk);
    endtask

    // Random batch of held requests, served in circular order from the
    // model's pointer; timing derived from the documented latencies.
    task automatic random_round();
        logic [3:0] mask;
        logic [3:0] s [4];
        logic [3:0] e [4];
        logic [1:0] q;
        int         order [$];
        int         t_load [$];
        int         t_done [$];
        int         arb_cyc;
        int         end_cyc;
        int         len;
        logic [3:0] exp_gnt;
        logic [3:0] exp_done;
        logic       exp_load;
        logic       exp_rst;
        logic       dout_chk;
        logic [3:0] exp_din;
        logic [3:0] exp_dout;

        mask = 4'($urandom_range(1, 15));
        for (int i = 0; i < 4; i++) begin
            s[i]     = 4'($urandom);
            e[i]     = 4'($urandom);
            drv_s[i] = s[i];
            drv_e[i] = e[i];
        end
        for (int k = 0; k < 4; k++) begin
            q = 2'((m_ptr + k) % 4);
            if (mask[q]) order.push_back(int'(q));
        end
        arb_cyc = 0;
        foreach (order[k]) begin
            len = int'(4'(e[order[k]] - s[order[k]])) + 1;
            t_load.push_back(arb_cyc + 1);
            t_done.push_back(arb_cyc + 2 + len);
            arb_cyc = arb_cyc + 3 + len;
        end
        end_cyc = arb_cyc;
        m_ptr   = (order[order.size() - 1] + 1) % 4;

        drive_vals();
        bus.req = mask;
        for (int c = 0; c <= end_cyc; c++) begin
            exp_gnt  = '0;
            exp_done = '0;
            exp_load = 1'b0;
            exp_rst  = 1'b1;
            dout_chk = 1'b0;
            exp_din  = '0;
            exp_dout = '0;
            foreach (order[k]) begin
                if (c >= t_load[k] && c <= t_done[k]) exp_gnt = 4'(1 << order[k]);
                if (c == t_done[k]) exp_done = 4'(1 << order[k]);
                if (c >= t_load[k] && c < t_done[k]) exp_rst = 1'b0;
                if (c == t_load[k]) begin
                    exp_load = 1'b1;
                    exp_din  = s[order[k]];
                end
                if (c > t_load[k] && c < t_done[k]) begin
                    dout_chk = 1'b1;
                    exp_dout = 4'(s[order[k]] + 4'(c - t_load[k] - 1));
                end
            end
            chk("rnd gnt",     32'(bus.gnt), 32'(exp_gnt));
            chk("rnd done",    32'(bus.done), 32'(exp_done));
            chk("rnd busy",    32'(bus.busy), 32'(exp_gnt != 4'd0));
            chk("rnd cnt_rst", 32'(cnt_rst), 32'(exp_rst));
            chk("rnd cnt_load", 32'(cnt_load), 32'(exp_load));
            if (exp_load) chk("rnd data_in", 32'(cnt_data_in), 32'(exp_din));
            if (dout_chk) chk("rnd data_out", 32'(cnt_data_out), 32'(exp_dout));
            // Values of already-granted requesters must be ignored.
            foreach (order[k]) begin
                if (c >= t_load[k]) begin
                    drv_s[order[k]] = 4'($urandom);
                    drv_e[order[k]] = 4'($urandom);
                end
                if (c == t_done[k]) bus.req[order[k]] = 1'b0;
            end
            drive_vals();
            @(negedge clk);
        end
    endtask

    initial begin
        logic [3:0] exp_gnt;
        logic [3:0] exp_done;
        int         k;

        n_checks = 0;
        n_fail   = 0;
        m_ptr    = 0;
        rst      = 1'b1;
        bus.req  = '0;
        for (int i = 0; i < 4; i++) begin
            drv_s[i] = '0;
            drv_e[i] = '0;
        end
        drive_vals();

        vecs[0] = '{0, 4'd3,  4'd7,  5};
        vecs[1] = '{1, 4'd14, 4'd1,  4};
        vecs[2] = '{2, 4'd5,  4'd5,  1};
        vecs[3] = '{3, 4'd0,  4'd15, 16};
        vecs[4] = '{1, 4'd15, 4'd0,  2};
        vecs[5] = '{0, 4'd9,  4'd8,  16};
        vecs[6] = '{3, 4'd10, 4'd12, 3};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst gnt",      32'(bus.gnt), 32'd0);
        chk("rst done",     32'(bus.done), 32'd0);
        chk("rst busy",     32'(bus.busy), 32'd0);
        chk("rst cnt_rst",  32'(cnt_rst), 32'd1);
        chk("rst cnt_load", 32'(cnt_load), 32'd0);
        chk("rst data_in",  32'(cnt_data_in), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Table-driven single transactions
        for (int v = 0; v < 7; v++) begin
            run_single(vecs[v].idx, vecs[v].s, vecs[v].e, vecs[v].run_len, $sformatf("vec%0d", v));
        end

        // Round robin: all four held high, start 0, end 2 -> period of 6 cycles
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drv_s[i] = 4'd0;
            drv_e[i] = 4'd2;
        end
        drive_vals();
        bus.req = 4'b1111;
        for (int c = 0; c <= 30; c++) begin
            exp_gnt  = '0;
            exp_done = '0;
            k = (c - 1) / 6;
            if (c >= 1 && c <= 29 && ((c - 1) % 6) <= 4) exp_gnt = 4'(1 << (k % 4));
            if (c >= 1 && c <= 29 && ((c - 1) % 6) == 4) exp_done = 4'(1 << (k % 4));
            chk($sformatf("rr gnt c%0d", c),  32'(bus.gnt), 32'(exp_gnt));
            chk($sformatf("rr done c%0d", c), 32'(bus.done), 32'(exp_done));
            if (c == 29) bus.req = '0;
            @(negedge clk);
        end

        // Abort of requester 3 in its second RUN cycle
        do_reset();
        drv_s[3] = 4'd0;
        drv_e[3] = 4'd10;
        drv_s[0] = 4'd1;
        drv_e[0] = 4'd2;
        drv_s[2] = 4'd4;
        drv_e[2] = 4'd4;
        drive_vals();
        bus.req = 4'b1000;
        @(negedge clk);
        chk("abort gnt_load", 32'(bus.gnt), 32'b1000);
        @(negedge clk);
        bus.req = 4'b1101;
        chk("abort done_run1", 32'(bus.done), 32'd0);
        @(negedge clk);
        chk("abort gnt_run2",  32'(bus.gnt), 32'b1000);
        chk("abort done_run2", 32'(bus.done), 32'd0);
        bus.req = 4'b0101;
        @(negedge clk);
        chk("abort gnt_drop", 32'(bus.gnt), 32'd0);
        chk("abort no_done",  32'(bus.done), 32'd0);
        chk("abort cnt_rst",  32'(cnt_rst), 32'd1);
        chk("abort busy",     32'(bus.busy), 32'd0);
        @(negedge clk);
        chk("abort next_gnt", 32'(bus.gnt), 32'b0001);
        chk("abort no_done3", 32'(bus.done), 32'd0);

        // Asynchronous reset mid-RUN
        do_reset();
        run_single(1, 4'd2, 4'd4, 3, "prerst");
        drv_s[2] = 4'd0;
        drv_e[2] = 4'd9;
        drive_vals();
        bus.req = 4'b0100;
        @(negedge clk);
        chk("arst gnt_load", 32'(bus.gnt), 32'b0100);
        @(negedge clk);
        @(negedge clk);
        chk("arst running", 32'(bus.busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst gnt",      32'(bus.gnt), 32'd0);
        chk("arst done",     32'(bus.done), 32'd0);
        chk("arst busy",     32'(bus.busy), 32'd0);
        chk("arst cnt_load", 32'(cnt_load), 32'd0);
        chk("arst cnt_rst",  32'(cnt_rst), 32'd1);
        bus.req = 4'b1111;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("arst ptr0", 32'(bus.gnt), 32'b0001);

        // Randomized batches against the schedule model
        do_reset();
        for (int r = 0; r < 40; r++) begin
            random_round();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/upcnt_seq_arbiter.md
Name: upcnt_seq_arbiter

Overview:
- Sequencer and arbiter for the shared 4-bit up-counter: grants the counter to one of NUM_REQ requesters at a time.
- For the granted requester, loads its start value, lets the counter run until it reaches that requester's end value, then pulses done.
- Sits between requester blocks and the counter's data_in/load/rst/data_out interface; the counter itself is unchanged.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 4, counter data width; must match the counter

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester request, level; held high until done or abort
- start_val  input  NUM_REQ*WIDTH  packed per-requester load value, sampled at grant
- end_val  input  NUM_REQ*WIDTH  packed per-requester terminal value, sampled at grant
- gnt  output  NUM_REQ  one-hot ownership, high from grant through the DONE state
- done  output  NUM_REQ  one-cycle pulse to owner on terminal match
- busy  output  1  high in any state except IDLE
- cnt_rst  output  1  drives counter rst
- cnt_load  output  1  drives counter load
- cnt_data_in  output  WIDTH  drives counter data_in
- cnt_data_out  input  WIDTH  counter data_out

Behaviour:
- Counter contract:
  - On a clk edge with load=1, data_out takes data_in.
  - Otherwise data_out increments by 1, wrapping from 2^WIDTH-1 to 0.
  - rst=1 forces data_out to 0.
- Reset values (asynchronous): state=IDLE, gnt=0, done=0, busy=0, cnt_rst=1, cnt_load=0, cnt_data_in=0, rr pointer=0, latched start/end=0.
- All outputs are registered or decoded from state only; there is no combinational path from req to gnt.
- FSM states: IDLE, LOAD, RUN, DONE.
- IDLE:
  - cnt_rst=1, counter held at 0.
  - If any req is high, the round-robin arbiter picks the first set req at or after the pointer.
  - Latches owner index, start_val[owner] and end_val[owner]; next state LOAD, with gnt[owner]=1 from LOAD onward.
- LOAD (1 cycle): cnt_rst=0, cnt_load=1, cnt_data_in=latched start; next state RUN.
- RUN:
  - cnt_load=0, cnt_data_in=0; counter free-increments.
  - When cnt_data_out == latched end, next state is DONE.
  - RUN lasts ((end - start) mod 2^WIDTH) + 1 cycles; start==end gives 1 cycle.
  - Wrap-around is legal and always terminates within 2^WIDTH cycles.
- DONE (1 cycle):
  - done[owner]=1, gnt[owner] still 1, cnt_rst=1.
  - Pointer becomes owner+1 mod NUM_REQ; next state IDLE, gnt drops.
- Latency from req rising in IDLE (cycle 0): gnt at cycle 1, data_out=start at cycle 2, done at cycle 2 + RUN length.
- Abort:
  - If req[owner] falls in LOAD or RUN, the next state is IDLE.
  - No done pulse; gnt drops on the next cycle; pointer still advances past owner.
- req falling during DONE is ignored; done still pulses.
- New requests arriving while busy wait; the arbiter evaluates only in IDLE.
- There is a one-IDLE-cycle gap between consecutive grants.
- start_val and end_val changes after grant are ignored.
- Asynchronous reset mid-operation returns everything to reset values immediately; no done pulse is produced.

Decomposition:
- Package upcnt_seq_pkg holds:
  - state enum type (IDLE, LOAD, RUN, DONE)
  - WIDTH default constant
  - function for the index to one-hot conversion
- Sub-module rr_arbiter (NUM_REQ):
  - inputs: req, pointer, enable
  - outputs: one-hot grant, binary index, valid
  - purely combinational, instantiated once; pointer register stays in the parent.

Test Plan:
- Single request: req[0]=1, start=3, end=7 after reset -> gnt[0] at cycle 1; cnt_load high 1 cycle with cnt_data_in=3; data_out 3,4,5,6,7; done[0] pulse the cycle after data_out=7; gnt[0] drops next cycle.
- Wrap: req[1], start=14, end=1 -> data_out 14,15,0,1 (RUN=4 cycles), then done[1].
- start==end=5 on req[2] -> RUN=1 cycle, done[2] two cycles after LOAD.
- Round robin:
  - All four req high from reset with start=0, end=2 -> grants in order 0,1,2,3,0.
  - Each grant is separated by LOAD + 3 RUN + DONE + 1 IDLE.
- Abort: drop req[3] in the 2nd RUN cycle -> gnt[3] low next cycle, done[3] never asserted, cnt_rst=1, next grant goes to requester 0.
- Reset mid-RUN: assert rst asynchronously -> gnt/done/busy/cnt_load go 0 and cnt_rst goes 1 without waiting for clk; after release the pointer restarts at 0.
